// File: rtl/rc4_key_search_ctrl.sv
// RC4 key-search sequencer: steps a key range through the init/shuffle/decrypt engines and screens the plaintext.
// Define KEYSEARCH_EARLY_ABORT_EN to abandon a decrypt pass on its first byte that is not a lowercase letter or space.
module rc4_key_search_ctrl #(
    parameter int KEY_WIDTH = 24,
    parameter int MSG_LEN   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [KEY_WIDTH-1:0] key_lo,
    input  logic [KEY_WIDTH-1:0] key_hi,
    input  logic                 init_finish,
    input  logic                 shuffle_finish,
    input  logic                 decrypt_finish,
    input  logic                 char_valid,
    input  logic [7:0]           char_data,
    output logic                 init_start,
    output logic                 shuffle_start,
    output logic                 decrypt_start,
    output logic                 decrypt_abort,
    output logic [1:0]           mem_sel,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic [KEY_WIDTH-1:0] attempts
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_INIT, S_SHUFFLE, S_DECRYPT, S_CHECK, S_NEXT, S_FOUND, S_EXHAUSTED
    } state_e;

    // Counter saturates one or more above MSG_LEN so an over-long pass never matches.
    localparam int CNT_W = $clog2(MSG_LEN + 2);

    state_e               state_q, state_d;
    logic                 entry_q;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [KEY_WIDTH-1:0] key_hi_q, key_hi_d;
    logic [KEY_WIDTH-1:0] attempts_q, attempts_d;
    logic [CNT_W-1:0]     char_cnt_q, char_cnt_d;
    logic                 bad_q, bad_d;
    logic                 char_bad;

    assign char_bad = char_valid &&
                      !(((char_data >= 8'h61) && (char_data <= 8'h7A)) || (char_data == 8'h20));

    // entry_q marks the first cycle of a state: the start-pulse cycle, on which finish is ignored.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= (state_d != state_q);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      if (start) state_d = S_LOAD;
                S_LOAD:      state_d = (key_hi < key_lo) ? S_EXHAUSTED : S_INIT;
                S_INIT:      if (!entry_q && init_finish) state_d = S_SHUFFLE;
                S_SHUFFLE:   if (!entry_q && shuffle_finish) state_d = S_DECRYPT;
                S_DECRYPT: begin
`ifdef KEYSEARCH_EARLY_ABORT_EN
                    if (char_bad || (!entry_q && decrypt_finish)) state_d = S_CHECK;
`else
                    if (!entry_q && decrypt_finish) state_d = S_CHECK;
`endif
                end
                S_CHECK: begin
                    if (!bad_q && (char_cnt_q == CNT_W'(MSG_LEN))) state_d = S_FOUND;
                    else if (key_q == key_hi_q)                    state_d = S_EXHAUSTED;
                    else                                           state_d = S_NEXT;
                end
                S_NEXT:      state_d = S_INIT;
                S_FOUND:     if (start) state_d = S_LOAD;
                S_EXHAUSTED: if (start) state_d = S_LOAD;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        init_start    = 1'b0;
        shuffle_start = 1'b0;
        decrypt_start = 1'b0;
        mem_sel       = 2'd0;
        case (state_q)
            S_INIT: begin
                mem_sel    = 2'd1;
                init_start = entry_q;
            end
            S_SHUFFLE: begin
                mem_sel       = 2'd2;
                shuffle_start = entry_q;
            end
            S_DECRYPT: begin
                mem_sel       = 2'd3;
                decrypt_start = entry_q;
            end
            default: mem_sel = 2'd0;
        endcase
        busy      = !(state_q inside {S_IDLE, S_FOUND, S_EXHAUSTED});
        found     = (state_q == S_FOUND);
        exhausted = (state_q == S_EXHAUSTED);
    end

    // Key range, attempt counter and plaintext screening; stop freezes all of it.
    always_comb begin
        key_d      = key_q;
        key_hi_d   = key_hi_q;
        attempts_d = attempts_q;
        char_cnt_d = char_cnt_q;
        bad_d      = bad_q;
        if (!stop) begin
            case (state_q)
                S_LOAD: begin
                    key_d      = key_lo;
                    key_hi_d   = key_hi;
                    attempts_d = '0;
                end
                S_DECRYPT: begin
                    if (char_valid && (char_cnt_q != '1)) char_cnt_d = char_cnt_q + 1'b1;
                    if (char_bad) bad_d = 1'b1;
                end
                S_CHECK: if (attempts_q != '1) attempts_d = attempts_q + 1'b1;
                S_NEXT:  key_d = key_q + 1'b1;
                default: ;
            endcase
            if ((state_d == S_DECRYPT) && (state_q != S_DECRYPT)) begin
                char_cnt_d = '0;
                bad_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q      <= '0;
            key_hi_q   <= '0;
            attempts_q <= '0;
            char_cnt_q <= '0;
            bad_q      <= 1'b0;
        end else begin
            key_q      <= key_d;
            key_hi_q   <= key_hi_d;
            attempts_q <= attempts_d;
            char_cnt_q <= char_cnt_d;
            bad_q      <= bad_d;
        end
    end

`ifdef KEYSEARCH_EARLY_ABORT_EN
    logic abort_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) abort_q <= 1'b0;
        else          abort_q <= (state_q == S_DECRYPT) && char_bad && !stop;
    end

    assign decrypt_abort = abort_q;
`else
    assign decrypt_abort = 1'b0;
`endif

    assign secret_key = key_q;
    assign attempts   = attempts_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Self-checking bench for rc4_key_search_ctrl: reactive engine emulation, randomized key ranges and plaintext.
module tb_rc4_key_search_ctrl;

    localparam int KW = 24;
    localparam int ML = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [KW-1:0] key_lo = '0;
    logic [KW-1:0] key_hi = '0;
    logic          init_finish = 1'b0;
    logic          shuffle_finish = 1'b0;
    logic          decrypt_finish = 1'b0;
    logic          char_valid = 1'b0;
    logic [7:0]    char_data = 8'h00;
    logic          init_start, shuffle_start, decrypt_start, decrypt_abort;
    logic [1:0]    mem_sel;
    logic [KW-1:0] secret_key, attempts;
    logic          busy, found, exhausted;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rc4_key_search_ctrl #(.KEY_WIDTH(KW), .MSG_LEN(ML)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .key_lo(key_lo), .key_hi(key_hi),
        .init_finish(init_finish), .shuffle_finish(shuffle_finish), .decrypt_finish(decrypt_finish),
        .char_valid(char_valid), .char_data(char_data),
        .init_start(init_start), .shuffle_start(shuffle_start), .decrypt_start(decrypt_start),
        .decrypt_abort(decrypt_abort), .mem_sel(mem_sel), .secret_key(secret_key),
        .busy(busy), .found(found), .exhausted(exhausted), .attempts(attempts)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pick_good();
        int r;
        r = $urandom_range(0, 26);
        return (r == 26) ? 8'h20 : 8'(8'h61 + r);
    endfunction

    function automatic logic [7:0] pick_bad();
        case ($urandom_range(0, 7))
            0: return 8'h41;
            1: return 8'h60;
            2: return 8'h7B;
            3: return 8'h1F;
            4: return 8'h21;
            5: return 8'h00;
            6: return 8'hFF;
            default: return 8'h5A;
        endcase
    endfunction

    task automatic drive_fin(input int p);
        case (p)
            1: init_finish = 1'b1;
            2: shuffle_finish = 1'b1;
            3: decrypt_finish = 1'b1;
            default: ;
        endcase
    endtask

    task automatic clear_drive();
        init_finish = 1'b0; shuffle_finish = 1'b0; decrypt_finish = 1'b0;
        char_valid = 1'b0; char_data = 8'h00;
    endtask

    task automatic wait_start(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            clear_drive();
            case (which)
                1: ok = init_start;
                2: ok = shuffle_start;
                default: ok = decrypt_start;
            endcase
        end
    endtask

    // Called at a falling edge; acts as all three engines and predicts the final search outcome.
    task automatic run_search(input int lo, input int hi, input int good, input logic [7:0] bad_ch,
                              input bit noisy);
        int exp_key, phase, exp_start, lat, ci, bad_pos, post, exp_att, exp_sk;
        bit exp_busy, fin_pend, exp_abort, done, is_bad, exp_found;
        logic [2:0] starts;
        exp_key = lo; phase = 0; lat = 0; ci = 0; bad_pos = 0; post = 0;
        fin_pend = 1'b0; exp_abort = 1'b0; done = 1'b0;
        key_lo = lo[KW-1:0]; key_hi = hi[KW-1:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_busy", busy, 1);
        exp_busy  = (lo <= hi);
        exp_start = exp_busy ? 1 : 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            clear_drive();
            starts = {decrypt_start, shuffle_start, init_start};
            check("start_pulse", starts, (exp_start == 0) ? 0 : (1 << (exp_start - 1)));
            check("busy", busy, exp_busy);
            check("decrypt_abort", decrypt_abort, exp_abort);
            exp_abort = 1'b0;
            if (!busy || !exp_busy) begin
                done = 1'b1;
            end else if (exp_start != 0) begin
                phase = exp_start; exp_start = 0;
                lat = $urandom_range(1, 4); ci = 0; fin_pend = 1'b0;
                bad_pos = $urandom_range(0, ML - 1);
                if (phase == 1) check("key_under_test", secret_key, exp_key);
                check("mem_sel", mem_sel, phase);
                if (noisy && $urandom_range(0, 1) == 1) drive_fin(phase);
            end else begin
                check("mem_sel", mem_sel, phase);
                case (phase)
                    0: begin
                        if (post == 1) begin
                            if (exp_key == good || exp_key == hi) exp_busy = 1'b0;
                            else post = 2;
                        end else if (post == 2) begin
                            exp_start = 1; exp_key++; post = 0;
                        end
                    end
                    1, 2: begin
                        if (lat <= 1) begin
                            drive_fin(phase);
                            exp_start = phase + 1;
                        end else begin
                            lat--;
                        end
                    end
                    default: begin
                        if (fin_pend) begin
                            decrypt_finish = 1'b1; phase = 0; post = 1;
                        end else if (ci < ML && $urandom_range(0, 3) != 0) begin
                            is_bad = (exp_key != good) && (ci == bad_pos);
                            char_valid = 1'b1;
                            char_data  = is_bad ? bad_ch : pick_good();
                            ci++;
                            if (ci == ML) begin
                                if ($urandom_range(0, 1) == 1) begin
                                    decrypt_finish = 1'b1; phase = 0; post = 1;
                                end else begin
                                    fin_pend = 1'b1;
                                end
                            end
`ifdef KEYSEARCH_EARLY_ABORT_EN
                            if (is_bad) begin
                                phase = 0; post = 1; exp_abort = 1'b1;
                            end
`endif
                        end
                    end
                endcase
            end
            if (!done && noisy) begin
                for (int q = 1; q <= 3; q++)
                    if (q != phase && $urandom_range(0, 3) == 0) drive_fin(q);
            end
        end
        check("search_terminated", done, 1);
        if (lo > hi) begin
            exp_found = 1'b0; exp_att = 0; exp_sk = lo;
        end else if (good >= lo && good <= hi) begin
            exp_found = 1'b1; exp_att = good - lo + 1; exp_sk = good;
        end else begin
            exp_found = 1'b0; exp_att = hi - lo + 1; exp_sk = hi;
        end
        check("found", found, exp_found);
        check("exhausted", exhausted, !exp_found);
        check("secret_key", secret_key, exp_sk);
        check("attempts", attempts, exp_att);
        check("done_mem_sel", mem_sel, 0);
        repeat (3) @(negedge clk);
        check("hold_found", found, exp_found);
        check("hold_key", secret_key, exp_sk);
        check("hold_busy", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lo, span, good;

        // Reset state
        #1;
        check("rst_pulses", {init_start, shuffle_start, decrypt_start, decrypt_abort}, 0);
        check("rst_flags", {busy, found, exhausted, mem_sel}, 0);
        check("rst_key", secret_key, 0);
        check("rst_attempts", attempts, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_flags", {busy, found, exhausted, mem_sel}, 0);

        // Start latency: init_start two edges after start is sampled
        key_lo = 24'd5; key_hi = 24'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_load_init_start", init_start, 0);
        check("t1_load_mem_sel", mem_sel, 0);
        @(negedge clk);
        check("t1_init_start", init_start, 1);
        check("t1_init_mem_sel", mem_sel, 1);
        check("t1_key", secret_key, 5);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t1_stop_busy", busy, 0);
        check("t1_stop_mem_sel", mem_sel, 0);
        check("t1_stop_key_held", secret_key, 5);

        // Directed searches
        run_search(0, 3, 2, pick_bad(), 1'b0);
        run_search(32'h3FFFFE, 32'h3FFFFF, -1, 8'h41, 1'b1);
        run_search(4, 1, -1, 8'h41, 1'b0);

        // Stop in SHUFFLE, later shuffle_finish ignored
        key_lo = 24'd7; key_hi = 24'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_start(1, ok);
        check("t5_init_seen", ok, 1);
        @(negedge clk);
        init_finish = 1'b1;
        wait_start(2, ok);
        check("t5_shuffle_seen", ok, 1);
        check("t5_shuffle_mem_sel", mem_sel, 2);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t5_stop_busy", busy, 0);
        check("t5_stop_mem_sel", mem_sel, 0);
        check("t5_stop_flags", {found, exhausted}, 0);
        check("t5_stop_key_held", secret_key, 7);
        shuffle_finish = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t5_ignored_finish", {busy, mem_sel, decrypt_start, shuffle_start}, 0);
        end
        shuffle_finish = 1'b0;

        // Asynchronous reset during DECRYPT
        key_lo = 24'h123; key_hi = 24'h124; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_start(1, ok);
        @(negedge clk);
        init_finish = 1'b1;
        wait_start(2, ok);
        @(negedge clk);
        shuffle_finish = 1'b1;
        wait_start(3, ok);
        check("t6_decrypt_seen", ok, 1);
        @(negedge clk);
        check("t6_decrypt_mem_sel", mem_sel, 3);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_outputs",
              {init_start, shuffle_start, decrypt_start, decrypt_abort, mem_sel, busy, found, exhausted}, 0);
        check("t6_rst_key", secret_key, 0);
        check("t6_rst_attempts", attempts, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Randomized ranges, noisy finish lines
        for (int n = 0; n < 8; n++) begin
            lo   = $urandom_range(24'hFFFFF0, 0);
            span = $urandom_range(0, 4);
            good = lo + $urandom_range(0, span + 1);
            run_search(lo, lo + span, good, pick_bad(), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
